// File: rtl/bit_serializer_if.sv
// Parallel-in / bit-serial-out port bundle for the bit serializer.
// The serializer sits on the slave side; the word source and serial consumer use master.
interface bit_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             xout;
  logic             xvalid;
  logic             frame_start;

  modport master (
    output din, din_valid,
    input  din_ready, xout, xvalid, frame_start
  );

  modport slave (
    input  din, din_valid,
    output din_ready, xout, xvalid, frame_start
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word pending buffer, so consecutive words
// stream out back to back with no gap bit. Each bit is held CLKS_PER_BIT clocks.
module bit_serializer #(
  parameter int unsigned WIDTH        = 8,
  parameter bit          MSB_FIRST    = 1'b1,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  bit_serializer_if.slave  bus
);

  localparam int unsigned BIT_W  = $clog2(WIDTH);
  localparam int unsigned HOLD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WIDTH - 1);
  localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(CLKS_PER_BIT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   pbuf_q, pbuf_d;
  logic               pvalid_q, pvalid_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic               din_ready_q;
  logic               xvalid_q;
  logic               frame_start_q;
  logic               accept;
  logic               bit_end;
  logic               word_end;
  logic               load;

  // Next-state: accept into pbuf, shift/count while SHIFT, reload from pbuf on word boundary
  always_comb begin
    state_d    = state_q;
    pbuf_d     = pbuf_q;
    pvalid_d   = pvalid_q;
    sreg_d     = sreg_q;
    bit_cnt_d  = bit_cnt_q;
    hold_cnt_d = hold_cnt_q;

    accept   = bus.din_valid && din_ready_q;
    bit_end  = (hold_cnt_q == LAST_HOLD);
    word_end = bit_end && (bit_cnt_q == LAST_BIT);
    load     = pvalid_q && ((state_q == IDLE) || ((state_q == SHIFT) && word_end));

    if (accept) begin
      pbuf_d   = bus.din;
      pvalid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
      end
      SHIFT: begin
        if (bit_end) begin
          hold_cnt_d = '0;
          // Zero fill: after the last shift the register is empty, which keeps xout low in IDLE
          sreg_d     = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
          bit_cnt_d  = word_end ? '0 : bit_cnt_q + BIT_W'(1);
          if (word_end) begin
            state_d = IDLE;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      sreg_d     = pbuf_q;
      bit_cnt_d  = '0;
      hold_cnt_d = '0;
      pvalid_d   = 1'b0;
      state_d    = SHIFT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      pbuf_q        <= '0;
      pvalid_q      <= 1'b0;
      sreg_q        <= '0;
      bit_cnt_q     <= '0;
      hold_cnt_q    <= '0;
      din_ready_q   <= 1'b1;
      xvalid_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pbuf_q        <= pbuf_d;
      pvalid_q      <= pvalid_d;
      sreg_q        <= sreg_d;
      bit_cnt_q     <= bit_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      din_ready_q   <= !pvalid_d;
      xvalid_q      <= (state_d == SHIFT);
      frame_start_q <= load;
    end
  end

  assign bus.din_ready   = din_ready_q;
  assign bus.xvalid      = xvalid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.xout        = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: default, LSB-first and 3-clocks-per-bit instances
// checked against hand-computed serial streams, back-to-back words and mid-word reset.
module tb_bit_serializer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  bit_serializer_if #(.WIDTH(8)) if0 ();
  bit_serializer_if #(.WIDTH(8)) if1 ();
  bit_serializer_if #(.WIDTH(8)) if2 ();

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .CLKS_PER_BIT(1)) dut0 (
    .clk(clk), .reset(reset), .bus(if0)
  );
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1)
  );
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .CLKS_PER_BIT(3)) dut2 (
    .clk(clk), .reset(reset), .bus(if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Samples n cycles at negedge; first sample lands in the most significant used bit
  task automatic capture(input int sel, input int n,
                         output logic [31:0] xo, output logic [31:0] xv, output logic [31:0] fs);
    xo = '0; xv = '0; fs = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      case (sel)
        0:       begin xo = {xo[30:0], if0.xout}; xv = {xv[30:0], if0.xvalid}; fs = {fs[30:0], if0.frame_start}; end
        1:       begin xo = {xo[30:0], if1.xout}; xv = {xv[30:0], if1.xvalid}; fs = {fs[30:0], if1.frame_start}; end
        default: begin xo = {xo[30:0], if2.xout}; xv = {xv[30:0], if2.xvalid}; fs = {fs[30:0], if2.frame_start}; end
      endcase
    end
  endtask

  logic [31:0] xo, xv, fs;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    if0.din = '0; if0.din_valid = 1'b0;
    if1.din = '0; if1.din_valid = 1'b0;
    if2.din = '0; if2.din_valid = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_xout",   32'(if0.xout),        32'd0);
    check("rst_xvalid", 32'(if0.xvalid),      32'd0);
    check("rst_fstart", 32'(if0.frame_start), 32'd0);
    check("rst_ready",  32'(if0.din_ready),   32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single word 1101_0110, MSB first
    if0.din = 8'hD6; if0.din_valid = 1'b1;
    fork
      capture(0, 11, xo, xv, fs);
      begin
        @(negedge clk);
        if0.din_valid = 1'b0;
        check("a_ready_low", 32'(if0.din_ready), 32'd0);
      end
    join
    check("a_xout",   xo, 32'h358);
    check("a_xvalid", xv, 32'h3FC);
    check("a_fstart", fs, 32'h200);
    repeat (2) @(negedge clk);

    // Back-to-back B5, 3C with din_valid held; din change while not ready is ignored
    if0.din = 8'hB5; if0.din_valid = 1'b1;
    fork
      capture(0, 19, xo, xv, fs);
      begin
        @(negedge clk);
        check("b_ready_k1", 32'(if0.din_ready), 32'd0);
        if0.din = 8'h3C;
        @(negedge clk);
        check("b_ready_k2", 32'(if0.din_ready), 32'd1);
        @(negedge clk);
        if0.din_valid = 1'b0;
        check("b_ready_k3", 32'(if0.din_ready), 32'd0);
        repeat (7) @(negedge clk);
        check("b_ready_k10", 32'(if0.din_ready), 32'd1);
      end
    join
    check("b_xout",   xo, 32'h2D4F0);
    check("b_xvalid", xv, 32'h3FFFC);
    check("b_fstart", fs, 32'h20200);
    repeat (2) @(negedge clk);

    // LSB first, word 01
    if1.din = 8'h01; if1.din_valid = 1'b1;
    fork
      capture(1, 11, xo, xv, fs);
      begin
        @(negedge clk);
        if1.din_valid = 1'b0;
      end
    join
    check("c_xout",   xo, 32'h200);
    check("c_xvalid", xv, 32'h3FC);
    repeat (2) @(negedge clk);

    // Three clocks per bit, word A0
    if2.din = 8'hA0; if2.din_valid = 1'b1;
    fork
      capture(2, 26, xo, xv, fs);
      begin
        @(negedge clk);
        if2.din_valid = 1'b0;
      end
    join
    check("d_xout",   xo, 32'h1C70000);
    check("d_xvalid", xv, 32'h1FFFFFE);
    check("d_fstart", fs, 32'h1000000);
    repeat (2) @(negedge clk);

    // Reset during bit 4 with a pending word: everything aborts at once
    if0.din = 8'hFF; if0.din_valid = 1'b1;
    repeat (3) @(negedge clk);
    if0.din_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("e_xvalid_pre", 32'(if0.xvalid),   32'd1);
    check("e_xout_pre",   32'(if0.xout),     32'd1);
    check("e_ready_pre",  32'(if0.din_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("e_xout_rst",   32'(if0.xout),        32'd0);
    check("e_xvalid_rst", 32'(if0.xvalid),      32'd0);
    check("e_fstart_rst", 32'(if0.frame_start), 32'd0);
    check("e_ready_rst",  32'(if0.din_ready),   32'd1);
    @(negedge clk);
    reset = 1'b1;
    capture(0, 12, xo, xv, fs);
    check("e_xvalid_post", xv, 32'h0);
    check("e_xout_post",   xo, 32'h0);

    // First word after reset release keeps the normal latency
    if0.din = 8'h81; if0.din_valid = 1'b1;
    fork
      capture(0, 11, xo, xv, fs);
      begin
        @(negedge clk);
        if0.din_valid = 1'b0;
      end
    join
    check("f_xout",   xo, 32'h204);
    check("f_xvalid", xv, 32'h3FC);
    check("f_fstart", fs, 32'h200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
